// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the century-clock counters.
//   - BCD digit widths for the day display
//   - day_t: packed {ten, unit} BCD day pair
//   - Day constants DAY_FIRST, DAY_28, DAY_29, DAY_30, DAY_31
//   - month_len_e: month-length classification
//   - len_to_day(): maps a month length onto its last-day BCD pair
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam int DAY_UNIT_W = 4;
  localparam int DAY_TEN_W  = 2;

  // Ten digit sits in the upper bits, so a plain vector compare of two day_t
  // values orders them tens-first, then units.
  typedef struct packed {
    logic [DAY_TEN_W-1:0]  ten;
    logic [DAY_UNIT_W-1:0] unit;
  } day_t;

  localparam day_t DAY_FIRST = {2'd0, 4'd1};
  localparam day_t DAY_28    = {2'd2, 4'd8};
  localparam day_t DAY_29    = {2'd2, 4'd9};
  localparam day_t DAY_30    = {2'd3, 4'd0};
  localparam day_t DAY_31    = {2'd3, 4'd1};

  typedef enum logic [1:0] {
    LEN_28,
    LEN_29,
    LEN_30,
    LEN_31
  } month_len_e;

  function automatic day_t len_to_day(input month_len_e len);
    case (len)
      LEN_28:  return DAY_28;
      LEN_29:  return DAY_29;
      LEN_30:  return DAY_30;
      default: return DAY_31;
    endcase
  endfunction

endpackage

// File: rtl/month_len_decode.sv
// -----------------------------------------------------------------------------
// month_len_decode
// Combinational last-day decode from the month counter's length flags.
// Priority TN > T > TO; with no flag set the month is treated as 31 days.
// Ports:
//   TO     in  current month has 31 days
//   T      in  current month has 30 days
//   TN     in  current month is February
//   leap   in  current year is a leap year
//   o_last out last day of the month as a BCD {ten, unit} pair
// -----------------------------------------------------------------------------
module month_len_decode
  import clock_pkg::*;
(
  input  logic TO,
  input  logic T,
  input  logic TN,
  input  logic leap,
  output day_t o_last
);

  month_len_e w_len;

  always_comb begin
    w_len = LEN_31;
    if (TN) begin
      w_len = leap ? LEN_29 : LEN_28;
    end else if (T) begin
      w_len = LEN_30;
    end else if (TO) begin
      w_len = LEN_31;
    end else begin
      // Invalid/unknown month: fall back to the longest length.
      w_len = LEN_31;
    end
  end

  assign o_last = len_to_day(w_len);

endmodule

// File: rtl/count_day.sv
// -----------------------------------------------------------------------------
// count_day
// BCD day-of-month counter. Advances on en_dy, rolls over after the last day
// of the month (raising pulse_dy for the month counter in the same cycle),
// supports set-mode up/down adjust, and clamps the day down when the month or
// leap status shortens the current month.
// Ports:
//   clk       in  system clock
//   rst_n     in  synchronous active-low reset (day -> 01)
//   en_dy     in  one-cycle day-advance carry from the hour counter
//   up        in  set-mode increment request
//   down      in  set-mode decrement request
//   TO/T/TN   in  month-length flags (31 / 30 / February)
//   leap      in  leap-year flag
//   day_unit  out BCD units digit
//   day_ten   out BCD tens digit
//   pulse_dy  out month-advance carry (en_dy & at last day), combinational
// -----------------------------------------------------------------------------
module count_day
  import clock_pkg::*;
#(
  parameter int MAX_DISPLAY_UNIT = 4,
  parameter int MAX_DISPLAY_TEN  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_dy,
  input  logic                        up,
  input  logic                        down,
  input  logic                        TO,
  input  logic                        T,
  input  logic                        TN,
  input  logic                        leap,
  output logic [MAX_DISPLAY_UNIT-1:0] day_unit,
  output logic [MAX_DISPLAY_TEN-1:0]  day_ten,
  output logic                        pulse_dy
);

  day_t r_day;
  day_t w_next;
  day_t w_last;
  logic w_at_last;
  logic w_over;

  function automatic day_t bcd_inc(input day_t d);
    day_t res;
    if (d.unit == 4'd9) begin
      res.unit = 4'd0;
      res.ten  = d.ten + 2'd1;
    end else begin
      res.unit = d.unit + 4'd1;
      res.ten  = d.ten;
    end
    return res;
  endfunction

  function automatic day_t bcd_dec(input day_t d);
    day_t res;
    if (d.unit == 4'd0) begin
      res.unit = 4'd9;
      res.ten  = d.ten - 2'd1;
    end else begin
      res.unit = d.unit - 4'd1;
      res.ten  = d.ten;
    end
    return res;
  endfunction

  month_len_decode u_len (
    .TO     (TO),
    .T      (T),
    .TN     (TN),
    .leap   (leap),
    .o_last (w_last)
  );

  // Packed {ten, unit} compares tens first, then units.
  assign w_at_last = (r_day >= w_last);
  assign w_over    = (r_day >  w_last);

  always_comb begin
    w_next = r_day;
    if (en_dy) begin
      w_next = w_at_last ? DAY_FIRST : bcd_inc(r_day);
    end else if (w_over) begin
      // Month/leap changed under us: pull back to the new last day.
      w_next = w_last;
    end else if (up && !down) begin
      w_next = w_at_last ? DAY_FIRST : bcd_inc(r_day);
    end else if (down && !up) begin
      w_next = (r_day == DAY_FIRST) ? w_last : bcd_dec(r_day);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_day <= DAY_FIRST;
    end else begin
      r_day <= w_next;
    end
  end

  assign day_unit = MAX_DISPLAY_UNIT'(r_day.unit);
  assign day_ten  = MAX_DISPLAY_TEN'(r_day.ten);

  // Only the run-mode carry rolls the month; adjust wraps and clamps do not.
  assign pulse_dy = en_dy & w_at_last;

endmodule

// File: tb/tb_count_day.sv
module tb_count_day;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_dy, up, down;
  logic       TO, T, TN, leap;
  logic [3:0] day_unit;
  logic [1:0] day_ten;
  logic       pulse_dy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: day as a plain integer 1..31.
  int m_day   = 1;
  bit m_valid = 1'b0;

  count_day #(.MAX_DISPLAY_UNIT(4), .MAX_DISPLAY_TEN(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_dy    (en_dy),
    .up       (up),
    .down     (down),
    .TO       (TO),
    .T        (T),
    .TN       (TN),
    .leap     (leap),
    .day_unit (day_unit),
    .day_ten  (day_ten),
    .pulse_dy (pulse_dy)
  );

  always #5 clk = ~clk;

  function automatic int last_day(input logic to_f, t_f, tn_f, lp);
    if (tn_f) return lp ? 29 : 28;
    if (t_f)  return 30;
    return 31;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_day();
    if ($isunknown({day_ten, day_unit})) return -1;
    return int'(day_ten) * 10 + int'(day_unit);
  endfunction

  // Model update on the active edge.
  always @(posedge clk) begin
    int lst;
    lst = last_day(TO, T, TN, leap);
    if (!rst_n) begin
      m_day   = 1;
      m_valid = 1'b1;
    end else if (en_dy && m_day >= lst) m_day = 1;
    else if (en_dy)                      m_day = m_day + 1;
    else if (m_day > lst)                m_day = lst;
    else if (up && !down)                m_day = (m_day >= lst) ? 1 : m_day + 1;
    else if (down && !up)                m_day = (m_day == 1) ? lst : m_day - 1;
  end

  // Per-cycle compare away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_day", dut_day(), m_day);
      check("model_pulse", int'(pulse_dy),
            int'(en_dy && (m_day >= last_day(TO, T, TN, leap))));
      check("bcd_unit_range", int'(day_unit <= 4'd9), 1);
    end
  end

  // One cycle of stimulus: applied just after an edge, acts on the next edge.
  task automatic drive(input logic e, input logic u, input logic d);
    @(posedge clk);
    #1;
    en_dy = e;
    up    = u;
    down  = d;
  endtask

  task automatic set_flags(input logic to_f, t_f, tn_f, lp);
    TO = to_f; T = t_f; TN = tn_f; leap = lp;
  endtask

  task automatic day_is(input string name, input int exp);
    check(name, dut_day(), exp);
  endtask

  initial begin
    rst_n = 1'b0;
    en_dy = 1'b1; up = 1'b1; down = 1'b0;
    set_flags(1, 0, 0, 0);

    // Reset held across two edges with en_dy and up high.
    @(posedge clk); #1;
    @(posedge clk); #1;
    day_is("reset_day", 1);
    #1 check("reset_pulse", int'(pulse_dy), 0);
    rst_n = 1'b1;
    en_dy = 1'b0; up = 1'b0;
    repeat (3) drive(0, 0, 0);
    day_is("idle_after_reset", 1);

    // 31-day month.
    repeat (30) begin
      drive(1, 0, 0);
      drive(0, 0, 0);
    end
    day_is("to_day31", 31);
    drive(1, 0, 0);
    #1 check("to_pulse_at31", int'(pulse_dy), 1);
    drive(0, 0, 0);
    day_is("to_wrap01", 1);

    // February, non-leap.
    set_flags(0, 0, 1, 0);
    repeat (27) drive(1, 0, 0);
    drive(0, 0, 0);
    day_is("feb_day28", 28);
    drive(1, 0, 0);
    #1 check("feb_pulse28", int'(pulse_dy), 1);
    drive(0, 0, 0);
    day_is("feb_wrap01", 1);

    // February, leap.
    leap = 1'b1;
    repeat (27) drive(1, 0, 0);
    drive(1, 0, 0);
    #1 check("leap_nopulse28", int'(pulse_dy), 0);
    drive(1, 0, 0);
    #1 check("leap_pulse29", int'(pulse_dy), 1);
    drive(0, 0, 0);
    day_is("leap_wrap01", 1);

    // Adjust wrap in a 30-day month.
    set_flags(0, 1, 0, 0);
    drive(0, 0, 1);
    drive(0, 0, 0);
    day_is("down_wrap30", 30);
    drive(0, 1, 0);
    #1 check("up_wrap_nopulse", int'(pulse_dy), 0);
    drive(0, 0, 0);
    day_is("up_wrap01", 1);
    repeat (9) drive(0, 1, 0);
    drive(0, 0, 0);
    day_is("up_to10", 10);
    drive(0, 0, 1);
    drive(0, 0, 0);
    day_is("down_10_09", 9);
    drive(0, 1, 0);
    drive(0, 0, 0);
    day_is("up_09_10", 10);

    // Clamp 31 -> 28 when the month changes to non-leap February.
    set_flags(1, 0, 0, 0);
    repeat (21) drive(0, 1, 0);
    drive(0, 0, 0);
    day_is("adj_to31", 31);
    set_flags(0, 0, 1, 0);
    drive(0, 0, 0);
    #1 check("clamp_nopulse", int'(pulse_dy), 0);
    drive(0, 0, 0);
    day_is("clamp_28", 28);

    // Priority cases at day 15.
    set_flags(1, 0, 0, 0);
    repeat (13) drive(0, 0, 1);
    drive(0, 0, 0);
    day_is("adj_to15", 15);
    drive(0, 1, 1);
    drive(0, 0, 0);
    day_is("updown_hold15", 15);
    drive(1, 0, 1);
    drive(0, 0, 0);
    day_is("en_beats_down16", 16);

    // No flags: treated as a 31-day month.
    set_flags(0, 0, 0, 0);
    repeat (15) drive(0, 1, 0);
    drive(0, 0, 0);
    day_is("noflag_day31", 31);
    drive(0, 1, 0);
    drive(0, 0, 0);
    day_is("noflag_wrap01", 1);

    // Reset wins over a simultaneous en_dy.
    repeat (4) drive(1, 0, 0);
    drive(1, 0, 0);
    rst_n = 1'b0;
    drive(0, 0, 0);
    rst_n = 1'b1;
    day_is("reset_midrun", 1);
    drive(0, 0, 0);
    drive(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_day.md
Name: count_day

Overview:
- BCD day-of-month counter for the century clock. It is the consumer end of the month counter's month-length flags (TO/T/TN).
- Advances on the day-enable carry from the hour counter. At the last day of the month it rolls over and generates the enable that drives the month counter's en_mo.
- Supports manual up/down adjust in set mode.
- Clamps the day automatically when the month or leap status shortens the current month.

Parameters:
- MAX_DISPLAY_UNIT, 4, width of day_unit BCD digit
- MAX_DISPLAY_TEN, 2, width of day_ten BCD digit

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- en_dy  input  1  one-cycle day-advance carry from the hour counter (run mode)
- up  input  1  set-mode increment request, one cycle per step
- down  input  1  set-mode decrement request, one cycle per step
- TO  input  1  current month has 31 days
- T  input  1  current month has 30 days
- TN  input  1  current month is February
- leap  input  1  current year is a leap year (from the year counter)
- day_unit  output  MAX_DISPLAY_UNIT  BCD units digit of day
- day_ten  output  MAX_DISPLAY_TEN  BCD tens digit of day
- pulse_dy  output  1  month-advance carry; connects to month en_mo

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-low.
  - On a rising clk edge with rst_n=0: day_ten=0, day_unit=1 (day 01). No other state exists.
- Last-day decode (combinational), priority TN > T > TO:
  - TN=1: last = leap ? 29 : 28.
  - else T=1: last = 30.
  - else: last = 31. This includes TO=1 and the no-flag case, so an invalid month is treated as 31 days.
- at_last = (day >= last), comparing BCD tens then units.
- Per-cycle update, first match wins:
  1. en_dy=1 and at_last: day <= 01.
  2. en_dy=1: BCD increment. Unit 9 gives unit 0 and ten+1; otherwise unit+1.
  3. day > last (month or leap changed under the counter): day <= last.
  4. up=1, down=0: if at_last, day <= 01; else BCD increment.
  5. down=1, up=0: if day==01, day <= last; if unit==0, unit 9 and ten-1; else unit-1.
  6. Otherwise hold. This covers up and down both high, and both low.
- While en_dy=1, up and down are ignored. Adjust only acts when en_dy=0.
- pulse_dy = en_dy & at_last.
  - Combinational from registered day and the current inputs.
  - Asserted in the same cycle as the en_dy that causes the rollover, so the month counter steps on the same edge that day returns to 01.
  - Never asserted by up/down wrap, and never asserted by a clamp.
- Day is never 00 and never above 31. Digit patterns outside valid BCD cannot be reached from reset.
- Reset mid-operation: a reset asserted in the same cycle as en_dy or up/down wins. Day goes to 01 and the registered state holds no pending carry. pulse_dy in that cycle follows its combinational equation.
- Latency: one clock from en_dy/up/down to the updated digits. Zero cycles from en_dy to pulse_dy.

Decomposition:
- Shared package (clock_pkg):
  - BCD digit widths.
  - Day constants DAY_FIRST=01, DAY_28, DAY_29, DAY_30, DAY_31 as {ten,unit} pairs.
  - Month-length enum {LEN_28, LEN_29, LEN_30, LEN_31}.
- Sub-module month_len_decode: combinational, takes TO/T/TN/leap and outputs the last-day BCD pair.
  - Reusable by the future date-validation and alarm blocks.
- count_day holds the register, the compare, and the update mux.

Test Plan:
- Reset: hold rst_n=0 across two edges with en_dy=1 and up=1 -> day=01, pulse_dy=0; after release, day stays 01 until the next en_dy.
- 31-day run (TO=1): apply 30 en_dy pulses from 01 -> day=31. Next en_dy -> pulse_dy=1 that cycle, day=01 after the edge.
- February:
  - TN=1, leap=0, day=28, en_dy -> pulse_dy=1, day=01.
  - Repeat with leap=1 -> day=29 with no pulse at 28; at 29, en_dy gives pulse_dy=1, then 01.
- Adjust wrap:
  - T=1, day=01, down -> 30.
  - up at 30 -> 01, with pulse_dy=0 throughout.
  - down at 10 -> 09; up at 09 -> 10.
- Clamp: day=31 with TO=1, switch to TN=1, leap=0 with no en_dy/up/down -> day=28 after one edge, pulse_dy=0.
- Priority:
  - up=down=1 at day 15 -> holds 15.
  - en_dy=1 with down=1 at day 15 -> 16.
